// File: rtl/mmio_timer_responder.sv
// MMIO timer peripheral: 64-bit free-running MTIME, MTIMECMP, CTRL and STATUS
// behind a 32-byte window, with a fixed-latency MEM-stage handshake and a level irq.
module mmio_timer_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_store_type,
  input  logic [1:0]  req_load_type,
  input  logic        flush,
  output logic        d_ready,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        stall,
  output logic        irq
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [1:0]    st_q, st_d;
  logic [1:0]    ld_q, ld_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          pending_q, pending_d;
  logic          irq_q, irq_d;

  logic          req, hit, is_store, is_load, commit;
  logic [63:0]   sel_reg, wmask, wshift, merged, rd_val, byte_sh;

  assign req      = (req_store_type != 2'd0) || (req_load_type != 2'd0);
  assign hit      = req && (req_addr[63:5] == BASE_ADDR[63:5]);
  assign is_store = (st_q != 2'd0);
  assign is_load  = (ld_q != 2'd0) && !is_store;

  // Register selection, write-lane merge and read extraction all use the latched request
  always_comb begin
    unique case (addr_q[4:3])
      2'd0:    sel_reg = mtime_q;
      2'd1:    sel_reg = mtimecmp_q;
      2'd2:    sel_reg = {62'b0, ctrl_q};
      default: sel_reg = {63'b0, pending_q};
    endcase

    wmask  = '0;
    wshift = '0;
    unique case (st_q)
      2'd1: begin
        wmask  = 64'hFF << {addr_q[2:0], 3'b000};
        wshift = {56'b0, wdata_q[7:0]} << {addr_q[2:0], 3'b000};
      end
      2'd2: begin
        if (addr_q[2]) begin
          wmask  = {32'hFFFF_FFFF, 32'h0};
          wshift = {wdata_q[31:0], 32'h0};
        end else begin
          wmask  = {32'h0, 32'hFFFF_FFFF};
          wshift = {32'h0, wdata_q[31:0]};
        end
      end
      2'd3: begin
        wmask  = '1;
        wshift = wdata_q;
      end
      default: begin
        wmask  = '0;
        wshift = '0;
      end
    endcase
    merged = (sel_reg & ~wmask) | wshift;

    byte_sh = sel_reg >> {addr_q[2:0], 3'b000};
    unique case (ld_q)
      2'd1:    rd_val = {56'b0, byte_sh[7:0]};
      2'd2:    rd_val = addr_q[2] ? {32'b0, sel_reg[63:32]} : {32'b0, sel_reg[31:0]};
      2'd3:    rd_val = sel_reg;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    st_d    = st_q;
    ld_d    = ld_q;
    rdata_d = rdata_q;
    commit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hit && !flush) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          addr_d  = req_addr[4:0];
          wdata_d = req_wdata;
          st_d    = req_store_type;
          ld_d    = req_load_type;
        end
      end
      S_ACCESS: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          // Read data is captured on entry so it is stable for the whole RESP cycle
          if (is_load) rdata_d = rd_val;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        commit  = is_store && !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d_ready = ((state_q == S_IDLE) && hit) || (state_q == S_ACCESS) || (state_q == S_RESP);
  assign stall   = ((state_q == S_IDLE) && hit) || (state_q == S_ACCESS);
  assign d_valid = (state_q == S_RESP) && is_load && !flush;
  assign d_rdata = rdata_q;
  assign irq     = irq_q;

  always_comb begin
    mtime_d    = ctrl_q[0] ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    pending_d  = pending_q;

    if (commit) begin
      unique case (addr_q[4:3])
        2'd0:    mtime_d    = merged;
        2'd1:    mtimecmp_d = merged;
        2'd2:    ctrl_d     = merged[1:0];
        default: if (wmask[0] && wshift[0]) pending_d = 1'b0;
      endcase
    end

    // Match uses the pre-increment count; placed last so a set beats a same-cycle clear
    if (ctrl_q[0] && (mtime_q == mtimecmp_q)) pending_d = 1'b1;

    irq_d = pending_q & ctrl_q[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      st_q       <= '0;
      ld_q       <= '0;
      rdata_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ctrl_q     <= '0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      st_q       <= st_d;
      ld_q       <= ld_d;
      rdata_q    <= rdata_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder: handshake timing, lane merge/extract,
// counter wrap, compare interrupt, set-over-clear priority, flush and reset abort.
module tb_mmio_timer_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_store_type;
  logic [1:0]  req_load_type;
  logic        flush;
  logic        d_ready, d_valid, stall, irq;
  logic [63:0] d_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] rd;
  int          nvalid, nstall;
  logic        all_ready;

  mmio_timer_responder #(.BASE_ADDR(BASE), .LATENCY(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_store_type (req_store_type),
    .req_load_type  (req_load_type),
    .flush          (flush),
    .d_ready        (d_ready),
    .d_valid        (d_valid),
    .d_rdata        (d_rdata),
    .stall          (stall),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it until the RESP cycle has passed.
  task automatic access(input logic [1:0] st, input logic [1:0] ld,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output int nv, output int ns,
                        output logic rdy_all);
    logic done;
    int   n;
    req_addr       = addr;
    req_wdata      = wdata;
    req_store_type = st;
    req_load_type  = ld;
    #1;
    done    = 1'b0;
    n       = 0;
    nv      = 0;
    ns      = 0;
    rdata   = '0;
    rdy_all = 1'b1;
    while (!done && n < 40) begin
      if (!d_ready) rdy_all = 1'b0;
      if (stall) ns++;
      if (d_valid) begin
        nv++;
        rdata = d_rdata;
      end
      if (!stall) done = 1'b1;
      @(posedge clock);
      #1;
      req_store_type = 2'd0;
      req_load_type  = 2'd0;
      n++;
    end
    check("access_completes", {63'b0, done}, 64'd1);
  endtask

  initial begin
    reset          = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_store_type = 2'd0;
    req_load_type  = 2'd0;
    flush          = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_d_ready", {63'b0, d_ready}, 64'd0);
    check("rst_d_valid", {63'b0, d_valid}, 64'd0);
    check("rst_stall",   {63'b0, stall},   64'd0);
    check("rst_irq",     {63'b0, irq},     64'd0);
    check("rst_d_rdata", d_rdata,          64'd0);
    reset = 1'b1;

    // Reset lands while an MTIME store is in ACCESS
    req_addr       = BASE;
    req_wdata      = 64'h1234;
    req_store_type = 2'd3;
    #1;
    check("hit_comb_ready", {63'b0, d_ready}, 64'd1);
    @(posedge clock);
    #1;
    req_store_type = 2'd0;
    check("access_stall", {63'b0, stall}, 64'd1);
    reset = 1'b0;
    #1;
    check("async_rst_ready", {63'b0, d_ready}, 64'd0);
    check("async_rst_stall", {63'b0, stall},   64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      check("post_rst_idle", {61'b0, d_ready, d_valid, stall}, 64'd0);
    end
    access(2'd0, 2'd3, BASE, '0, rd, nvalid, nstall, all_ready);
    check("mtime_after_abort", rd, 64'd0);

    // MTIMECMP reset value and handshake shape
    access(2'd0, 2'd3, BASE + 64'h8, '0, rd, nvalid, nstall, all_ready);
    check("cmp_rst_rdata",  rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("cmp_valid_once", 64'(nvalid), 64'd1);
    check("cmp_stall_cyc",  64'(nstall), 64'd3);
    check("cmp_ready_held", {63'b0, all_ready}, 64'd1);

    // Byte lane write, then dword and upper-word reads
    access(2'd1, 2'd0, BASE + 64'hB, 64'hAB, rd, nvalid, nstall, all_ready);
    check("store_no_valid", 64'(nvalid), 64'd0);
    access(2'd0, 2'd3, BASE + 64'h8, '0, rd, nvalid, nstall, all_ready);
    check("byte_merge", rd, 64'hFFFF_FFFF_ABFF_FFFF);
    access(2'd0, 2'd2, BASE + 64'hC, '0, rd, nvalid, nstall, all_ready);
    check("word_upper", rd, 64'h0000_0000_FFFF_FFFF);

    // Flush during ACCESS of a CTRL store
    req_addr       = BASE + 64'h10;
    req_wdata      = 64'd5;
    req_store_type = 2'd3;
    @(posedge clock);
    #1;
    req_store_type = 2'd0;
    flush = 1'b1;
    #1;
    check("flush_in_access", {63'b0, d_ready}, 64'd1);
    check("flush_no_valid",  {63'b0, d_valid}, 64'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    #1;
    check("flush_idle", {61'b0, d_ready, d_valid, stall}, 64'd0);
    access(2'd0, 2'd3, BASE + 64'h10, '0, rd, nvalid, nstall, all_ready);
    check("ctrl_unchanged", rd, 64'd0);

    req_addr      = 64'h0000_0000_2000_0000;
    req_load_type = 2'd3;
    #1;
    check("miss_ready", {63'b0, d_ready}, 64'd0);
    check("miss_stall", {63'b0, stall},   64'd0);
    req_load_type = 2'd0;

    // Wrap and match: back-to-back accesses keep the cycle accounting exact
    access(2'd3, 2'd0, BASE,          64'hFFFF_FFFF_FFFF_FFFE, rd, nvalid, nstall, all_ready);
    access(2'd3, 2'd0, BASE + 64'h8,  64'd1, rd, nvalid, nstall, all_ready);
    access(2'd3, 2'd0, BASE + 64'h10, 64'd3, rd, nvalid, nstall, all_ready);
    access(2'd0, 2'd3, BASE,          '0,    rd, nvalid, nstall, all_ready);
    check("mtime_wrapped", rd, 64'd0);
    check("irq_lags_pending", {63'b0, irq}, 64'd0);
    @(posedge clock);
    #1;
    check("irq_rise", {63'b0, irq}, 64'd1);
    access(2'd0, 2'd3, BASE + 64'h18, '0, rd, nvalid, nstall, all_ready);
    check("status_pending", rd, 64'd1);
    access(2'd3, 2'd0, BASE + 64'h18, 64'd1, rd, nvalid, nstall, all_ready);
    @(posedge clock);
    #1;
    check("irq_cleared", {63'b0, irq}, 64'd0);
    access(2'd0, 2'd3, BASE + 64'h18, '0, rd, nvalid, nstall, all_ready);
    check("status_cleared", rd, 64'd0);

    // MTIME=100 lands; MTIMECMP commits at 103; the STATUS clear commits when MTIME=107
    access(2'd3, 2'd0, BASE,          64'd100, rd, nvalid, nstall, all_ready);
    access(2'd3, 2'd0, BASE + 64'h8,  64'd107, rd, nvalid, nstall, all_ready);
    access(2'd3, 2'd0, BASE + 64'h18, 64'd1,   rd, nvalid, nstall, all_ready);
    access(2'd0, 2'd3, BASE + 64'h18, '0,      rd, nvalid, nstall, all_ready);
    check("set_beats_clear", rd, 64'd1);
    check("irq_after_set",   {63'b0, irq}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
